dma_copy_master: RTL and testbench
==================================

// Module: dma_copy_master
// PURPOSE
//  Bus initiator that block-copies 32-bit words between data-memory / peripheral addresses.
//  Drives Address, Write_data, MemRead, MemWrite into the data-memory responder.
//  Consumes that responder's registered Read_data, valid one cycle after MemRead.
//  Sits beside the CPU; a mux (outside this block) grants it the bus while busy=1.
// PARAMETERS
//  ADDR_W  32  bus address width (byte address, word-aligned accesses)
//  DATA_W  32  bus data width
//  CNT_W   16  width of word-count register (max transfer 2^CNT_W-1 words)
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  reset       in   1       synchronous, active-high reset
//  start       in   1       1-cycle request; samples src_addr/dst_addr/word_count
//  abort       in   1       cancel in-flight transfer
//  src_addr    in   ADDR_W  first source byte address
//  dst_addr    in   ADDR_W  first destination byte address
//  word_count  in   CNT_W   number of words to copy
//  Read_data   in   DATA_W  responder read data (registered, 1-cycle latency)
//  Address     out  ADDR_W  bus address
//  Write_data  out  DATA_W  bus write data
//  MemRead     out  1       bus read strobe
//  MemWrite    out  1       bus write strobe
//  busy        out  1       transfer in progress (bus request)
//  done        out  1       1-cycle pulse on normal completion
//  remaining   out  CNT_W   words not yet written
//  err         out  1       sticky error flag (DMA_ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: state IDLE; Address, Write_data, remaining = 0; all strobes and flags = 0.
//  - IDLE: MemRead = MemWrite = 0. On start, latch src, dst, cnt.
//    - cnt == 0: pulse done next cycle, stay IDLE, busy stays 0.
//    - Otherwise go RD and set busy = 1.
//  - RD (1 cycle): Address = src, MemRead = 1; then src += 4 and go WR.
//  - WR (1 cycle): Address = dst, MemWrite = 1, Write_data = Read_data (combinational pass-through).
//    Then dst += 4, remaining -= 1. If remaining becomes 0: go IDLE, busy -> 0, done = 1 for one cycle.
//    Else go back to RD.
//  - Throughput: exactly 2 cycles per word; N words take 2N cycles from the first RD to done.
//  - Strobes are mutually exclusive; no cycle ever has MemRead and MemWrite both 1.
//  - Address arithmetic is modulo 2^ADDR_W and wraps silently; this is not an error.
//  - start while busy: ignored; latched values are unchanged.
//  - abort while busy: next state IDLE, busy -> 0, no done pulse, remaining frozen.
//    An abort in RD suppresses the following write.
//  - start and abort in the same cycle from IDLE: abort wins, nothing launched.
//  - reset mid-transfer: immediate return to the reset values above; the partially copied region is left as-is.
// CONFIGURATION
//  DMA_ALIGN_CHECK_EN defined:
//    - start with src_addr[1:0] != 0 or dst_addr[1:0] != 0 is rejected: stays IDLE, err sets.
//    - err clears only on reset or on the next accepted start.
//  DMA_ALIGN_CHECK_EN undefined:
//    - src/dst low 2 bits are forced to 0 on latch; err is constant 0.
// STRUCTURE
//  Shared package dma_pkg:
//    - state typedef {IDLE, RD, WR}
//    - WORD_BYTES = 4
//    - address-increment constant
//  One sub-module, dma_addr_gen: a loadable +4 address register, instantiated twice (src, dst).
//  Everything else lives in this module.
// TESTING
//  1. src=0x0, dst=0x100, cnt=3, memory[0..2] = A,B,C:
//     - strobes alternate R,W,R,W,R,W at addrs 0,0x100,4,0x104,8,0x108
//     - mem[0x100..0x108] = A,B,C; done at cycle 6; remaining = 0
//  2. cnt=0: no strobes, busy never 1, done pulses 1 cycle after start.
//  3. cnt=4, abort asserted during the 2nd RD:
//     - exactly 1 write issued, no done pulse, remaining = 3, busy = 0 next cycle
//  4. start pulsed again mid-transfer with other args: ignored, original copy completes unchanged.
//  5. src=0x40000004 (timer counter), dst=0x10, cnt=1: mem[0x10] = counter value captured at the RD cycle.
//  6. DMA_ALIGN_CHECK_EN defined, src=0x2:
//     - no strobes, err = 1
//     - then a valid start clears err and completes normally

Source files
------------

// File: rtl/dma_pkg.sv
// ============================================================================
// dma_pkg : shared types and constants for the dma_copy_master slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package dma_pkg;

   localparam int WORD_BYTES = 4;
   localparam int ADDR_INC   = WORD_BYTES;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/dma_copy_master_if.sv
// ============================================================================
// dma_copy_master_if : data-memory bus between the DMA initiator and responder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface dma_copy_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] Write_data;
   logic [DATA_W-1:0] Read_data;
   logic              MemRead;
   logic              MemWrite;

   modport master (
      output Address,
      output Write_data,
      output MemRead,
      output MemWrite,
      input  Read_data
   );

   modport slave (
      input  Address,
      input  Write_data,
      input  MemRead,
      input  MemWrite,
      output Read_data
   );

endinterface

`default_nettype wire

// File: rtl/dma_addr_gen.sv
// ============================================================================
// dma_addr_gen : loadable address register that steps by one word
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dma_addr_gen
   import dma_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_val_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;

   // Load has priority; the increment wraps modulo 2^ADDR_W by design.
   always_comb begin
      addr_d = addr_q;
      if (load_i) begin
         addr_d = load_val_i;
      end else if (inc_i) begin
         addr_d = addr_q + ADDR_W'(ADDR_INC);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/dma_copy_master.sv
// ============================================================================
// dma_copy_master : block-copy bus initiator, one read + one write per word
// Optional feature macro: DMA_ALIGN_CHECK_EN (reject unaligned src/dst, sticky err)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dma_copy_master
   import dma_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_W-1:0]    src_addr,
   input  logic [ADDR_W-1:0]    dst_addr,
   input  logic [CNT_W-1:0]     word_count,
   dma_copy_master_if.master    bus,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     remaining,
   output logic                 err
);

   dma_state_e        state_q;
   dma_state_e        state_d;
   logic [CNT_W-1:0]  remaining_q;
   logic [CNT_W-1:0]  remaining_d;
   logic              done_q;
   logic              done_d;

   logic [ADDR_W-1:0] w_src_load;
   logic [ADDR_W-1:0] w_dst_load;
   logic [ADDR_W-1:0] w_src_cur;
   logic [ADDR_W-1:0] w_dst_cur;
   logic              w_src_inc;
   logic              w_dst_inc;
   logic              w_align_ok;
   logic              w_start_req;
   logic              w_accept;

   logic [ADDR_W-1:0] w_address;
   logic [DATA_W-1:0] w_write_data;
   logic              w_mem_read;
   logic              w_mem_write;

   // A start is only considered from IDLE, and abort in the same cycle vetoes it.
   assign w_start_req = (state_q == IDLE) && start && !abort;
   assign w_accept    = w_start_req && w_align_ok;

`ifdef DMA_ALIGN_CHECK_EN
   logic err_q;

   assign w_align_ok = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00);
   assign w_src_load = src_addr;
   assign w_dst_load = dst_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (w_accept) begin
         err_q <= 1'b0;
      end else if (w_start_req) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign w_align_ok = 1'b1;
   assign w_src_load = src_addr & ~ADDR_W'(WORD_BYTES - 1);
   assign w_dst_load = dst_addr & ~ADDR_W'(WORD_BYTES - 1);
   assign err        = 1'b0;
`endif

   dma_addr_gen #(
      .ADDR_W     (ADDR_W)
   ) u_src_gen (
      .clk        (clk),
      .reset      (reset),
      .load_i     (w_accept),
      .load_val_i (w_src_load),
      .inc_i      (w_src_inc),
      .addr_o     (w_src_cur)
   );

   dma_addr_gen #(
      .ADDR_W     (ADDR_W)
   ) u_dst_gen (
      .clk        (clk),
      .reset      (reset),
      .load_i     (w_accept),
      .load_val_i (w_dst_load),
      .inc_i      (w_dst_inc),
      .addr_o     (w_dst_cur)
   );

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      done_d       = 1'b0;
      w_src_inc    = 1'b0;
      w_dst_inc    = 1'b0;
      w_address    = '0;
      w_write_data = '0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;

      case (state_q)
         IDLE: begin
            if (w_accept) begin
               remaining_d = word_count;
               if (word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RD;
               end
            end
         end

         RD: begin
            w_address  = w_src_cur;
            w_mem_read = 1'b1;
            w_src_inc  = 1'b1;
            state_d    = abort ? IDLE : WR;
         end

         WR: begin
            // Read_data is the responder's registered reply to the previous RD.
            w_address    = w_dst_cur;
            w_mem_write  = 1'b1;
            w_write_data = bus.Read_data;
            w_dst_inc    = 1'b1;
            remaining_d  = remaining_q - CNT_W'(1);
            if (abort) begin
               state_d = IDLE;
            end else if (remaining_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = RD;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
      end
   end

   assign bus.Address    = w_address;
   assign bus.Write_data = w_write_data;
   assign bus.MemRead    = w_mem_read;
   assign bus.MemWrite   = w_mem_write;

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign remaining = remaining_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_copy_master.sv
// ============================================================================
// tb_dma_copy_master : directed self-checking bench with a word memory + timer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dma_copy_master;
   import dma_pkg::*;

   localparam int          ADDR_W     = 32;
   localparam int          DATA_W     = 32;
   localparam int          CNT_W      = 16;
   localparam logic [31:0] TIMER_ADDR = 32'h4000_0004;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  remaining;
   logic              err;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   dma_copy_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dma_copy_master #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .word_count (word_count),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .remaining  (remaining),
      .err        (err)
   );

   function automatic logic [31:0] pat(input int i);
      return 32'hA500_0000 + 32'(i);
   endfunction

   // Responder: 512-word memory refilled with pat(i) during reset, plus a free-running timer.
   logic [31:0] mem [0:511];
   logic [31:0] timer_q = 32'h1234_0000;
   logic [31:0] rdata_q = 32'h0;

   always @(posedge clk) begin
      timer_q <= timer_q + 32'd1;
      if (reset) begin
         for (int i = 0; i < 512; i++) mem[i] <= pat(i);
      end else begin
         if (bus.MemRead)
            rdata_q <= (bus.Address == TIMER_ADDR) ? timer_q : mem[bus.Address[10:2]];
         if (bus.MemWrite)
            mem[bus.Address[10:2]] <= bus.Write_data;
      end
   end
   assign bus.Read_data = rdata_q;

   // Bus monitor sampled on the falling edge.
   logic        mon_clr = 1'b0;
   logic        tr_we   [0:31];
   logic [31:0] tr_addr [0:31];
   int          tr_n      = 0;
   int          done_cnt  = 0;
   int          overlap   = 0;
   logic        busy_seen = 1'b0;
   logic [31:0] tmr_cap   = 32'h0;

   always @(negedge clk) begin
      if (bus.MemRead && bus.MemWrite) overlap++;
      if (mon_clr) begin
         tr_n      = 0;
         done_cnt  = 0;
         busy_seen = 1'b0;
         tmr_cap   = 32'h0;
      end else begin
         if ((bus.MemRead || bus.MemWrite) && tr_n < 32) begin
            tr_we[tr_n]   = bus.MemWrite;
            tr_addr[tr_n] = bus.Address;
            tr_n++;
         end
         if (bus.MemRead && bus.Address == TIMER_ADDR) tmr_cap = timer_q;
         if (done) done_cnt++;
         if (busy) busy_seen = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      src_addr   = s;
      dst_addr   = d;
      word_count = n;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic chk_tr(input string tag, input int i, input logic we, input logic [31:0] a);
      check({tag, "_we"}, 32'(tr_we[i]), 32'(we));
      check({tag, "_addr"}, tr_addr[i], a);
   endtask

   int c;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; word_count = '0;
      tick(); tick();
      check("rst_addr", bus.Address, 32'h0);
      check("rst_wdata", bus.Write_data, 32'h0);
      check("rst_strobes", {30'd0, bus.MemRead, bus.MemWrite}, 32'h0);
      check("rst_flags", {29'd0, busy, done, err}, 32'h0);
      check("rst_remaining", 32'(remaining), 32'h0);
      reset = 1'b0;
      clear_mon();

      // 3-word copy 0x0 -> 0x100
      launch(32'h0, 32'h100, 16'd3);
      wait_done(c);
      check("t1_done_cyc", 32'(c), 32'd6);
      check("t1_ntr", 32'(tr_n), 32'd6);
      chk_tr("t1_0", 0, 1'b0, 32'h000);
      chk_tr("t1_1", 1, 1'b1, 32'h100);
      chk_tr("t1_2", 2, 1'b0, 32'h004);
      chk_tr("t1_3", 3, 1'b1, 32'h104);
      chk_tr("t1_4", 4, 1'b0, 32'h008);
      chk_tr("t1_5", 5, 1'b1, 32'h108);
      check("t1_busy_at_done", 32'(busy), 32'h0);
      check("t1_remaining", 32'(remaining), 32'h0);
      tick();
      check("t1_mem0", mem[64], pat(0));
      check("t1_mem1", mem[65], pat(1));
      check("t1_mem2", mem[66], pat(2));
      check("t1_done_len", 32'(done), 32'h0);

      // zero-length request
      clear_mon();
      launch(32'h40, 32'h140, 16'd0);
      check("t2_done", 32'(done), 32'h1);
      tick();
      check("t2_done_len", 32'(done), 32'h0);
      tick(); tick();
      check("t2_ntr", 32'(tr_n), 32'h0);
      check("t2_busy_seen", 32'(busy_seen), 32'h0);
      check("t2_done_cnt", 32'(done_cnt), 32'h1);

      // abort during the second read
      clear_mon();
      launch(32'h20, 32'h200, 16'd4);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t3_busy", 32'(busy), 32'h0);
      check("t3_remaining", 32'(remaining), 32'd3);
      repeat (4) tick();
      check("t3_done_cnt", 32'(done_cnt), 32'h0);
      check("t3_ntr", 32'(tr_n), 32'd3);
      chk_tr("t3_0", 0, 1'b0, 32'h020);
      chk_tr("t3_1", 1, 1'b1, 32'h200);
      chk_tr("t3_2", 2, 1'b0, 32'h024);
      check("t3_mem", mem[128], pat(8));
      check("t3_remaining_frozen", 32'(remaining), 32'd3);

      // restart while busy is ignored
      clear_mon();
      launch(32'h0, 32'h300, 16'd2);
      launch(32'h80, 32'h380, 16'd5);
      wait_done(c);
      check("t4_done_cyc", 32'(c + 1), 32'd4);
      check("t4_ntr", 32'(tr_n), 32'd4);
      chk_tr("t4_0", 0, 1'b0, 32'h000);
      chk_tr("t4_1", 1, 1'b1, 32'h300);
      chk_tr("t4_2", 2, 1'b0, 32'h004);
      chk_tr("t4_3", 3, 1'b1, 32'h304);
      tick();
      check("t4_mem0", mem[192], pat(0));
      check("t4_mem1", mem[193], pat(1));
      check("t4_untouched", mem[224], pat(224));

      // timer peripheral as source
      clear_mon();
      launch(TIMER_ADDR, 32'h10, 16'd1);
      wait_done(c);
      check("t5_done_cyc", 32'(c), 32'd2);
      chk_tr("t5_0", 0, 1'b0, TIMER_ADDR);
      chk_tr("t5_1", 1, 1'b1, 32'h10);
      tick();
      check("t5_mem", mem[4], tmr_cap);

      // source address wraps past the top of the address space
      clear_mon();
      launch(32'hFFFF_FFFC, 32'h600, 16'd2);
      wait_done(c);
      check("t6_done_cyc", 32'(c), 32'd4);
      chk_tr("t6_0", 0, 1'b0, 32'hFFFF_FFFC);
      chk_tr("t6_1", 1, 1'b1, 32'h600);
      chk_tr("t6_2", 2, 1'b0, 32'h000);
      chk_tr("t6_3", 3, 1'b1, 32'h604);
      tick();
      check("t6_mem0", mem[384], pat(511));
      check("t6_mem1", mem[385], pat(0));

      // unaligned addresses
      clear_mon();
`ifdef DMA_ALIGN_CHECK_EN
      launch(32'h2, 32'h500, 16'd1);
      check("t7_err", 32'(err), 32'h1);
      check("t7_busy", 32'(busy), 32'h0);
      repeat (3) tick();
      check("t7_ntr", 32'(tr_n), 32'h0);
      check("t7_done_cnt", 32'(done_cnt), 32'h0);
      check("t7_err_sticky", 32'(err), 32'h1);
      launch(32'h8, 32'h504, 16'd1);
      check("t7_err_clr", 32'(err), 32'h0);
      wait_done(c);
      check("t7_done_cyc", 32'(c), 32'd2);
      tick();
      check("t7_mem", mem[321], pat(2));
`else
      launch(32'h2, 32'h503, 16'd1);
      wait_done(c);
      check("t7_done_cyc", 32'(c), 32'd2);
      check("t7_err", 32'(err), 32'h0);
      chk_tr("t7_0", 0, 1'b0, 32'h000);
      chk_tr("t7_1", 1, 1'b1, 32'h500);
      tick();
      check("t7_mem", mem[320], pat(0));
`endif

      // start and abort together from IDLE
      clear_mon();
      abort = 1'b1;
      launch(32'h0, 32'h700, 16'd2);
      abort = 1'b0;
      check("t8_busy", 32'(busy), 32'h0);
      repeat (3) tick();
      check("t8_ntr", 32'(tr_n), 32'h0);
      check("t8_done_cnt", 32'(done_cnt), 32'h0);

      // reset in the middle of a transfer
      clear_mon();
      launch(32'h0, 32'h700, 16'd3);
      tick(); tick();
      reset = 1'b1;
      tick();
      check("t9_busy", 32'(busy), 32'h0);
      check("t9_remaining", 32'(remaining), 32'h0);
      check("t9_addr", bus.Address, 32'h0);
      check("t9_strobes", {30'd0, bus.MemRead, bus.MemWrite}, 32'h0);
      reset = 1'b0;
      tick();

      check("strobe_overlap", 32'(overlap), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
